dmem_bus_bridge: RTL and testbench

Sequential data-memory bridge in the MEM stage, directly downstream of the load/store unit.
- Takes one word-aligned load/store request per instruction: byte strobes come from the LSU; the raw 32-bit word is returned for LSU lane extraction.
- Drives a valid/ready request bus and waits for a response, with a per-access timeout.
- Stalls the pipeline until the access completes.

---
 rtl/dmem_pkg.sv | 26 ++
 rtl/dmem_timeout_ctr.sv | 41 ++++
 rtl/dmem_bus_bridge.sv | 199 +++++++++++++++++++
 tb/tb_dmem_bus_bridge.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data-memory bridge: FSM state
// encoding, access-size codes and the alignment rule used by the optional
// misalignment trap (DMEM_MISALIGN_TRAP_EN).
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } dmem_state_e;

   // Access size codes carried in sl_type[1:0]
   localparam logic [1:0] MEM_SZ_NONE = 2'b00;
   localparam logic [1:0] MEM_SZ_BYTE = 2'b01;
   localparam logic [1:0] MEM_SZ_HALF = 2'b10;
   localparam logic [1:0] MEM_SZ_WORD = 2'b11;

   // Half accesses need an even address, word accesses a multiple of four.
   function automatic logic is_misaligned(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
      return ((size == MEM_SZ_HALF) && addr_lo[0]) ||
             ((size == MEM_SZ_WORD) && (addr_lo != 2'b00));
   endfunction

endpackage

// File: rtl/dmem_timeout_ctr.sv
// Per-access timeout counter. Counts the cycles an access spends on the bus
// and flags expiry once the count has reached TIMEOUT_CYCLES; the count
// saturates there so expiry stays asserted until the counter is cleared.
module dmem_timeout_ctr #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: clear wins, otherwise count up while enabled, saturating at the limit
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && (cnt_q != LIMIT)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Count register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = enable && (cnt_q == LIMIT);

endmodule

// File: rtl/dmem_bus_bridge.sv
// MEM-stage data-memory bridge. Accepts one word-aligned load/store from the
// LSU, runs it over a valid/ready request bus, waits for the response and
// returns the raw 32-bit word with a one-cycle resp_valid pulse. The
// pipeline is stalled until the DONE cycle.
//
// Bus handshake: mem_req_valid is raised in REQ and, together with
// mem_we/mem_addr/mem_wdata/mem_wstrb, holds steady until a cycle in which
// mem_req_ready is also high; that cycle is the transfer. A response
// (mem_resp_valid) is only taken in the cycles after the transfer.
//
// Optional feature macro: DMEM_MISALIGN_TRAP_EN -- when defined, misaligned
// half/word accesses complete immediately with resp_err=1 and
// resp_misalign=1 and never reach the bus.
//
// dbg_state exposes the FSM state (dmem_state_e encoding) for observation.
module dmem_bus_bridge
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [3:0]        req_sl_type,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [3:0]        req_wstrb,
   output logic              stall,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              resp_misalign,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [3:0]        mem_wstrb,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_resp_err,
   output logic [1:0]        dbg_state
);

   localparam logic [1:0] S_IDLE = 2'(IDLE);
   localparam logic [1:0] S_REQ  = 2'(REQ);
   localparam logic [1:0] S_WAIT = 2'(WAIT);
   localparam logic [1:0] S_DONE = 2'(DONE);

   logic [1:0]        state_q, state_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [3:0]        wstrb_q, wstrb_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
`ifdef DMEM_MISALIGN_TRAP_EN
   logic              mis_q, mis_d;
`endif

   logic       expired;
   logic       in_done;
   logic [1:0] size;
   logic       unused_bits;

   assign size        = req_sl_type[1:0];
   assign in_done     = (state_q == S_DONE);
   // Store flag is taken from req_we; the sl_type class bits and, without the
   // trap, the low address bits carry no further information here.
   assign unused_bits = ^{req_sl_type[3:2], req_addr[1:0]};

   dmem_timeout_ctr #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .clear  (state_q == S_IDLE),
      .enable ((state_q == S_REQ) || (state_q == S_WAIT)),
      .expired(expired)
   );

   // Next-state and datapath-capture logic for the access FSM
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      rdata_d = rdata_q;
      err_d   = err_q;
`ifdef DMEM_MISALIGN_TRAP_EN
      mis_d   = mis_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
               wdata_d = req_wdata;
               wstrb_d = req_we ? req_wstrb : 4'b0000;
               rdata_d = '0;
               err_d   = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
               mis_d   = 1'b0;
`endif
               // A store that writes nothing completes without bus traffic
               if (req_we && ((req_wstrb == 4'b0000) || (size == MEM_SZ_NONE))) begin
                  state_d = S_DONE;
               end
`ifdef DMEM_MISALIGN_TRAP_EN
               else if (is_misaligned(size, req_addr[1:0])) begin
                  state_d = S_DONE;
                  err_d   = 1'b1;
                  mis_d   = 1'b1;
               end
`endif
               else begin
                  state_d = S_REQ;
               end
            end
         end
         S_REQ: begin
            if (expired) begin
               state_d = S_DONE;
               err_d   = 1'b1;
               rdata_d = '0;
            end else if (mem_req_ready) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            // Timeout beats a response arriving in the same cycle
            if (expired) begin
               state_d = S_DONE;
               err_d   = 1'b1;
               rdata_d = '0;
            end else if (mem_resp_valid) begin
               state_d = S_DONE;
               err_d   = mem_resp_err;
               rdata_d = (we_q || mem_resp_err) ? '0 : mem_rdata;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and latched-access registers, cleared by synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= 4'b0000;
         rdata_q <= '0;
         err_q   <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
         mis_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
`ifdef DMEM_MISALIGN_TRAP_EN
         mis_q   <= mis_d;
`endif
      end
   end

   assign stall         = req_valid && !in_done;
   assign resp_valid    = in_done;
   assign resp_rdata    = in_done ? rdata_q : '0;
   assign resp_err      = in_done && err_q;
`ifdef DMEM_MISALIGN_TRAP_EN
   assign resp_misalign = in_done && mis_q;
`else
   assign resp_misalign = 1'b0;
`endif
   // Request is withdrawn in the cycle the timeout fires
   assign mem_req_valid = (state_q == S_REQ) && !expired;
   assign mem_we        = we_q;
   assign mem_addr      = addr_q;
   assign mem_wdata     = wdata_q;
   assign mem_wstrb     = wstrb_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Testbench for dmem_bus_bridge: directed and randomized accesses with a
// responsive bus agent, checked against a cycle-count reference model.
module tb_dmem_bus_bridge;

   localparam int T = 8;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_we;
   logic [3:0]    req_sl_type;
   logic [W-1:0]  req_addr;
   logic [W-1:0]  req_wdata;
   logic [3:0]    req_wstrb;
   logic          stall;
   logic          resp_valid;
   logic [W-1:0]  resp_rdata;
   logic          resp_err;
   logic          resp_misalign;
   logic          mem_req_valid;
   logic          mem_req_ready;
   logic          mem_we;
   logic [W-1:0]  mem_addr;
   logic [W-1:0]  mem_wdata;
   logic [3:0]    mem_wstrb;
   logic          mem_resp_valid;
   logic [W-1:0]  mem_rdata;
   logic          mem_resp_err;
   logic [1:0]    dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   logic [W-1:0] exp_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   dmem_bus_bridge #(
      .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(T)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_we(req_we), .req_sl_type(req_sl_type),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .resp_misalign(resp_misalign),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_resp_valid(mem_resp_valid),
      .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err),
      .dbg_state(dbg_state)
   );

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_state"}, 32'(dbg_state), 32'd0);
      check_eq({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
      check_eq({tag, "_resp_rdata"}, resp_rdata, 32'd0);
      check_eq({tag, "_resp_err"}, 32'(resp_err), 32'd0);
      check_eq({tag, "_misalign"}, 32'(resp_misalign), 32'd0);
      check_eq({tag, "_mem_req_valid"}, 32'(mem_req_valid), 32'd0);
      check_eq({tag, "_stall"}, 32'(stall), 32'd0);
   endtask

   // ---------------- driver + reference model ----------------
   // One access: the model predicts latency and result from the bus agent's
   // delays; the agent answers the DUT's bus requests cycle by cycle.
   task automatic run_txn(input string tag, input logic we, input logic [1:0] size,
                          input logic [W-1:0] addr, input logic [W-1:0] wdata,
                          input logic [3:0] wstrb, input int ready_dly,
                          input int resp_dly, input logic [W-1:0] rdata,
                          input logic berr);
      int exp_lat, exp_req_cyc, lat, req_cyc, stall_cyc, req_seen, wait_seen;
      logic exp_err, exp_mis, exp_bus, mis, hs, saw_bus, done;
      logic got_err, got_mis;
      logic [W-1:0] exp_rd, got_rd;

      // reference model
      mis = ((size == 2'b10) && addr[0]) || ((size == 2'b11) && (addr[1:0] != 2'b00));
`ifndef DMEM_MISALIGN_TRAP_EN
      mis = 1'b0;
`endif
      exp_mis = 1'b0;
      if (we && (wstrb == 4'b0000)) begin
         exp_bus = 0; exp_lat = 1; exp_err = 0; exp_rd = 0; exp_req_cyc = 0;
      end else if (mis) begin
         exp_bus = 0; exp_lat = 1; exp_err = 1; exp_rd = 0; exp_req_cyc = 0; exp_mis = 1;
      end else if (ready_dly + resp_dly + 2 <= T) begin
         exp_bus = 1; exp_lat = ready_dly + resp_dly + 3; exp_err = berr;
         exp_rd = (we || berr) ? 32'd0 : rdata; exp_req_cyc = ready_dly + 1;
      end else begin
         exp_bus = 1; exp_lat = T + 2; exp_err = 1; exp_rd = 0;
         exp_req_cyc = (ready_dly + 1 <= T) ? ready_dly + 1 : T;
      end
      exp_q.push_back(exp_rd);

      @(posedge clk); #1;
      req_valid = 1'b1; req_we = we; req_sl_type = {we, 1'b0, size};
      req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
      mem_req_ready = 0; mem_resp_valid = 0; mem_resp_err = 0;

      lat = -1; req_cyc = 0; stall_cyc = 0; req_seen = 0; wait_seen = 0;
      hs = 0; saw_bus = 0; done = 0; got_rd = 0; got_err = 0; got_mis = 0;
      for (int k = 0; k < 60 && !done; k++) begin
         @(negedge clk);
         if (stall) stall_cyc++;
         if (mem_req_valid) begin
            saw_bus = 1; req_cyc++;
            check_eq({tag, "_mem_addr"}, mem_addr, {addr[W-1:2], 2'b00});
            check_eq({tag, "_mem_we"}, 32'(mem_we), 32'(we));
            check_eq({tag, "_mem_wstrb"}, 32'(mem_wstrb), we ? 32'(wstrb) : 32'd0);
            if (we) check_eq({tag, "_mem_wdata"}, mem_wdata, wdata);
         end
         if (resp_valid) begin
            lat = k; done = 1;
            got_rd = resp_rdata; got_err = resp_err; got_mis = resp_misalign;
            req_valid = 0; mem_req_ready = 0; mem_resp_valid = 0; mem_resp_err = 0;
         end else begin
            mem_resp_valid = 0; mem_resp_err = 0; mem_rdata = $urandom;
            if (hs) begin
               if (wait_seen >= resp_dly) begin
                  mem_resp_valid = 1; mem_rdata = rdata; mem_resp_err = berr;
               end
               wait_seen++;
            end
            mem_req_ready = 0;
            if (mem_req_valid) begin
               if (req_seen >= ready_dly) begin
                  mem_req_ready = 1; hs = 1;
                  // response noise in the transfer cycle must be ignored
                  mem_resp_valid = 1'($urandom_range(0, 1));
                  mem_resp_err = 1'($urandom_range(0, 1));
               end
               req_seen++;
            end
         end
      end
      if (!done) begin
         req_valid = 0; mem_req_ready = 0; mem_resp_valid = 0;
      end
      check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check_eq({tag, "_resp_rdata"}, got_rd, exp_q.pop_front());
      check_eq({tag, "_resp_err"}, 32'(got_err), 32'(exp_err));
      check_eq({tag, "_misalign"}, 32'(got_mis), 32'(exp_mis));
      check_eq({tag, "_stall_cycles"}, 32'(stall_cyc), 32'(exp_lat));
      check_eq({tag, "_bus_used"}, 32'(saw_bus), 32'(exp_bus));
      check_eq({tag, "_req_cycles"}, 32'(req_cyc), 32'(exp_req_cyc));
      // resp_valid is a single-cycle pulse and the bus goes quiet afterwards
      @(negedge clk);
      check_eq({tag, "_pulse"}, 32'(resp_valid), 32'd0);
      check_eq({tag, "_post_req_valid"}, 32'(mem_req_valid), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1; req_valid = 0; req_we = 0; req_sl_type = 0; req_addr = 0;
      req_wdata = 0; req_wstrb = 0; mem_req_ready = 0; mem_resp_valid = 0;
      mem_rdata = 0; mem_resp_err = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle_outputs("reset");
      check_eq("reset_mem_addr", mem_addr, 32'd0);
      check_eq("reset_mem_wstrb", 32'(mem_wstrb), 32'd0);
      check_eq("reset_mem_we", 32'(mem_we), 32'd0);
      check_eq("reset_mem_wdata", mem_wdata, 32'd0);
      @(posedge clk); #1; rst = 0;

      // directed
      run_txn("load_fast", 0, 2'b01, 32'h0000_1003, 32'h0, 4'h0, 0, 0, 32'hDEAD_BEEF, 0);
      run_txn("store_slow", 1, 2'b10, 32'h0000_2002, 32'hABCD_0000, 4'b1100, 4, 0, 32'h1234_5678, 0);
      run_txn("timeout_wait", 0, 2'b11, 32'h0000_3000, 32'h0, 4'h0, 0, 40, 32'h5555_AAAA, 0);
      run_txn("timeout_req", 1, 2'b11, 32'h0000_3004, 32'hCAFE_F00D, 4'hF, 40, 0, 32'h0, 0);
      run_txn("edge_ok", 0, 2'b11, 32'h0000_3008, 32'h0, 4'h0, 0, 6, 32'h0BAD_CAFE, 0);
      run_txn("edge_tmo", 0, 2'b11, 32'h0000_300C, 32'h0, 4'h0, 0, 7, 32'h0BAD_CAFE, 0);
      run_txn("store_nostrb", 1, 2'b11, 32'h0000_4000, 32'h1111_2222, 4'h0, 0, 0, 32'h0, 0);
      run_txn("bus_err", 0, 2'b11, 32'h0000_5000, 32'h0, 4'h0, 1, 1, 32'h7777_8888, 1);
      run_txn("half_mis", 0, 2'b10, 32'h0000_2001, 32'h0, 4'h0, 0, 0, 32'h4433_2211, 0);

      // reset in WAIT followed by a stray response
      @(posedge clk); #1;
      req_valid = 1; req_we = 0; req_sl_type = 4'b0011; req_addr = 32'h0000_6000;
      mem_req_ready = 1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      mem_req_ready = 0;
      check_eq("abort_in_wait", 32'(dbg_state), 32'd2);
      rst = 1;
      @(negedge clk);
      check_eq("abort_no_resp", 32'(resp_valid), 32'd0);
      @(posedge clk); #1;
      rst = 0; req_valid = 0;
      mem_resp_valid = 1; mem_rdata = 32'hFEED_FACE; mem_resp_err = 1;
      @(negedge clk);
      check_idle_outputs("abort_stray");
      @(posedge clk); #1;
      mem_resp_valid = 0; mem_resp_err = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_idle_outputs("abort_after");
      end

      // randomized
      for (int i = 0; i < 60; i++) begin
         logic rwe;
         logic [3:0] rstrb;
         rwe = 1'($urandom_range(0, 1));
         rstrb = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         run_txn("rand", rwe, 2'($urandom_range(1, 3)), $urandom, $urandom, rstrb,
                 $urandom_range(0, 4), $urandom_range(0, 5), $urandom,
                 ($urandom_range(0, 4) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global bound on run time
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation did not complete");
   end

endmodule
